// File: rtl/membus_reader_if.sv
// membus_reader_if: memory-bus request/response signals between the block reader and memory.
interface membus_reader_if;
    logic        membus_rq_cyc;
    logic        membus_rd_rq;
    logic [17:0] membus_ma;
    logic        membus_fmc_select;
    logic        membus_addr_ack;
    logic        membus_rd_rs;
    logic [35:0] membus_mb_in;
    modport master (
        output membus_rq_cyc, membus_rd_rq, membus_ma, membus_fmc_select,
        input  membus_addr_ack, membus_rd_rs, membus_mb_in
    );
    modport slave (
        input  membus_rq_cyc, membus_rd_rq, membus_ma, membus_fmc_select,
        output membus_addr_ack, membus_rd_rs, membus_mb_in
    );
endinterface

// File: rtl/membus_reader.sv
// membus_reader: reads a block of words over the memory bus, one cycle at a time, and streams them out.
// Define MEMBUS_TIMEOUT_EN to add the address-acknowledge watchdog that raises nxm.
module membus_reader (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [17:0]     start_addr,
    input  logic [17:0]     count,
    input  logic            fm_en,
    input  logic            abort,
    membus_reader_if.master bus,
    output logic [35:0]     out_word,
    output logic [17:0]     out_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            nxm
);
    typedef enum logic [2:0] {IDLE, REQ, ACKWAIT, DATAWAIT, OUT, FIN} state_t;
    state_t      r_state, w_next;
    logic [17:0] r_addr, r_count;
    logic        r_fm, r_pend, r_zdone;
    logic        w_go, w_zero, w_xfer, w_req, w_pend_set, w_timeout;

`ifdef MEMBUS_TIMEOUT_EN
    logic [9:0] r_wd;
    logic       r_nxm;
    assign w_timeout = (r_state == ACKWAIT) && !bus.membus_addr_ack && (r_wd == 10'h3ff);
    assign nxm       = r_nxm;
    // Watchdog sits at zero outside ACKWAIT, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd  <= '0;
            r_nxm <= 1'b0;
        end else begin
            r_wd  <= (r_state == ACKWAIT) ? r_wd + 10'd1 : '0;
            r_nxm <= w_go ? 1'b0 : (r_nxm | w_timeout);
        end
    end
`else
    assign w_timeout = 1'b0;
    assign nxm       = 1'b0;
`endif

    assign w_go       = start && (r_state == IDLE) && (count != '0);
    assign w_zero     = start && (r_state == IDLE) && (count == '0);
    assign w_xfer     = (r_state == OUT) && out_ready;
    assign w_req      = (r_state == REQ) || (r_state == ACKWAIT);
    // An abort that arrives once the memory has committed to a data cycle waits for the word.
    assign w_pend_set = abort && ((r_state == DATAWAIT) || ((r_state == ACKWAIT) && bus.membus_addr_ack));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_go ? REQ : IDLE;
            REQ:      w_next = abort ? FIN : ACKWAIT;
            ACKWAIT:  w_next = bus.membus_addr_ack ? DATAWAIT : (abort || w_timeout) ? FIN : ACKWAIT;
            DATAWAIT: w_next = bus.membus_rd_rs ? OUT : DATAWAIT;
            OUT:      w_next = w_xfer ? ((r_count == 18'd1 || r_pend || abort) ? FIN : REQ)
                                      : ((abort && !r_pend) ? FIN : OUT);
            FIN:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_count  <= '0;
            r_fm     <= 1'b0;
            r_pend   <= 1'b0;
            r_zdone  <= 1'b0;
            out_word <= '0;
            out_addr <= '0;
        end else begin
            r_state <= w_next;
            r_zdone <= w_zero;
            r_pend  <= (r_state == FIN) ? 1'b0 : (r_pend | w_pend_set);
            if (w_go) begin
                r_addr  <= start_addr;
                r_count <= count;
                r_fm    <= fm_en;
            end
            if (w_xfer) begin
                r_addr  <= r_addr + 18'd1;
                r_count <= r_count - 18'd1;
            end
            if ((r_state == DATAWAIT) && bus.membus_rd_rs) begin
                out_word <= bus.membus_mb_in;
                out_addr <= r_addr;
            end
        end
    end

    assign bus.membus_rq_cyc     = w_req;
    assign bus.membus_rd_rq      = w_req;
    assign bus.membus_ma         = w_req ? r_addr : '0;
    assign bus.membus_fmc_select = w_req && r_fm && (r_addr < 18'o20);
    assign out_valid             = (r_state == OUT);
    assign busy                  = (r_state != IDLE);
    assign done                  = (r_state == FIN) || r_zdone;
endmodule

// File: doc/membus_reader.md
MEMBUS_READER -- requirements
Module: membus_reader

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: start  input  1  one-cycle pulse that begins a block read; ignored while busy=1.
REQ-004 SHALL have port: start_addr  input  18  first word address, sampled on start.
REQ-005 SHALL have port: count  input  18  number of words to read, sampled on start.
REQ-006 SHALL have port: fm_en  input  1  fast-memory select, sampled on start.
REQ-007 SHALL have port: abort  input  1  terminates the block at the next safe point.
REQ-008 SHALL have port: membus_rq_cyc  output  1  cycle request to memory.
REQ-009 SHALL have port: membus_rd_rq  output  1  read request.
REQ-010 SHALL have port: membus_ma  output  18  word address.
REQ-011 SHALL have port: membus_fmc_select  output  1  fast-memory (AC 0-17) select.
REQ-012 SHALL have port: membus_addr_ack  input  1  memory has accepted the address.
REQ-013 SHALL have port: membus_rd_rs  input  1  read-restart strobe; data is valid on membus_mb_in.
REQ-014 SHALL have port: membus_mb_in  input  36  data from memory.
REQ-015 SHALL have port: out_word  output  36  word read from memory.
REQ-016 SHALL have port: out_addr  output  18  address of out_word.
REQ-017 SHALL have port: out_valid  output  1  out_word/out_addr are valid.
REQ-018 SHALL have port: out_ready  input  1  consumer accepts the word.
REQ-019 SHALL have port: busy  output  1  a block read is in progress.
REQ-020 SHALL have port: done  output  1  one-cycle pulse when a block ends.
REQ-021 SHALL have port: nxm  output  1  sticky nonexistent-memory flag.

Function
REQ-022 SHALL implement the states IDLE, REQ, ACKWAIT, DATAWAIT, OUT and FIN.
REQ-023 IDLE: on start with count!=0, SHALL latch addr/count/fm_en, clear nxm, set busy, and go to REQ on the next cycle.
REQ-024 IDLE: on start with count=0, SHALL pulse done one cycle later, leave busy=0, and leave nxm unchanged.
REQ-025 REQ: SHALL assert membus_rq_cyc=1 and membus_rd_rq=1 with membus_ma=addr, then go to ACKWAIT.
REQ-026 membus_fmc_select SHALL be 1 only when fm_en=1 and addr<0o20, and SHALL be held for the whole cycle.
REQ-027 ACKWAIT: SHALL hold the request until membus_addr_ack=1, then drop rq_cyc and rd_rq in the same edge and go to DATAWAIT.
REQ-028 DATAWAIT: on membus_rd_rs=1, SHALL capture membus_mb_in into out_word and addr into out_addr, set out_valid, and go to OUT.
REQ-029 DATAWAIT: membus_rd_rs SHALL be ignored in any other state.
REQ-030 OUT: out_valid, out_word and out_addr SHALL be held stable until out_valid&out_ready=1.
REQ-031 OUT: on the transfer edge, SHALL clear out_valid, set addr=addr+1 (mod 2^18, 0o777777 wraps to 0), and set count=count-1.
REQ-032 OUT: after the transfer, SHALL go to REQ if count!=0, else to FIN.
REQ-033 FIN: SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-034 abort SHALL take effect only in REQ, OUT, or ACKWAIT before addr_ack.
REQ-035 abort SHALL drop all requests and out_valid and go to FIN.
REQ-036 abort asserted in DATAWAIT SHALL be held pending until the data is captured, then take effect.
REQ-037 No more than one memory cycle SHALL be outstanding.
REQ-038 Two back-to-back words SHALL have a minimum gap of 1 cycle (REQ) between handshakes.

Reset
REQ-039 On reset=1, SHALL go to IDLE with all outputs 0, clear nxm, and clear the pending abort.
REQ-040 Reset SHALL override start and abort in the same cycle.
REQ-041 Reset during a memory cycle SHALL drop rq_cyc and rd_rq the following edge, with no done pulse.

Configuration
REQ-042 With MEMBUS_TIMEOUT_EN defined, a 10-bit watchdog SHALL count cycles in ACKWAIT.
REQ-043 With MEMBUS_TIMEOUT_EN, if 1024 cycles pass without addr_ack, SHALL set nxm=1, drop the request, and go to FIN.
REQ-044 With MEMBUS_TIMEOUT_EN, the watchdog SHALL reset on entry to ACKWAIT.
REQ-045 Without MEMBUS_TIMEOUT_EN, ACKWAIT SHALL wait indefinitely and nxm SHALL be constant 0.

Verification
REQ-046 start_addr=0o20, count=3, responder acks in 2 cycles, out_ready=1 -> out_addr 0o20,0o21,0o22 with matching core words, then one done pulse.
REQ-047 start_addr=0o777777, count=2 -> membus_ma 0o777777 then 0, with out_addr matching.
REQ-048 fm_en=1, start_addr=0o16, count=4 -> fmc_select=1 for 0o16,0o17 and 0 for 0o20,0o21.
REQ-049 out_ready held 0 for 10 cycles -> out_valid/out_word stable, no new rq_cyc until accepted.
REQ-050 count=0 -> done one cycle after start, no rq_cyc; abort in DATAWAIT -> word still delivered, then done.
REQ-051 MEMBUS_TIMEOUT_EN with no addr_ack -> nxm=1 and done at cycle 1024 of ACKWAIT, rq_cyc=0.
